// File: rtl/coherency_unit_mesi_n.sv
// MESI snooping coherency controller for one cache port on a shared bus.
// Accepts miss / upgrade / writeback requests from the cache, issues them on
// the bus, answers bus snoops by querying the cache, and replays a request
// that a snoop preempted. Keeps saturating MESI transition statistics.
module coherency_unit_mesi_n #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 2,
  parameter int CPUID        = 0,
  parameter int NCPUS        = 2,
  parameter int UPGRADE_MODE = 1,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_ren,
  input  logic                    req_wen,
  input  logic                    req_wb,
  input  logic                    req_upgrade,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [BLOCK_SIZE*32-1:0] req_wdata,
  output logic                    req_busy,
  output logic [BLOCK_SIZE*32-1:0] req_rdata,
  output logic [1:0]              req_state,
  output logic                    req_done,
  output logic                    snp_req,
  output logic [ADDR_WIDTH-1:0]   snp_addr,
  output logic [1:0]              snp_state,
  output logic                    snp_commit,
  input  logic                    snp_busy,
  input  logic                    snp_hit,
  input  logic                    snp_dirty,
  input  logic [BLOCK_SIZE*32-1:0] snp_data,
  output logic                    bus_ren,
  output logic                    bus_wen,
  output logic                    bus_rfo,
  output logic                    bus_upgr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [BLOCK_SIZE*32-1:0] bus_store,
  input  logic                    bus_dwait,
  input  logic                    bus_exclusive,
  input  logic                    bus_ccwait,
  input  logic                    bus_ccinv,
  input  logic [BLOCK_SIZE*32-1:0] bus_dload,
  input  logic [ADDR_WIDTH-1:0]   bus_snoopaddr,
  output logic                    bus_snoopdone,
  output logic                    bus_snoophit,
  output logic                    bus_dirty,
  output logic [STAT_WIDTH-1:0]   stat_to_m,
  output logic [STAT_WIDTH-1:0]   stat_to_e,
  output logic [STAT_WIDTH-1:0]   stat_to_s,
  output logic [STAT_WIDTH-1:0]   stat_to_i,
  output logic [STAT_WIDTH-1:0]   stat_snoop_hits
);

  localparam int DW  = BLOCK_SIZE * 32;
  localparam int LSB = $clog2(BLOCK_SIZE) + 2;
  localparam logic [STAT_WIDTH-1:0] ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_UP = 2'd2, K_WB = 2'd3;

  if (CPUID >= NCPUS || !(BLOCK_SIZE == 1 || BLOCK_SIZE == 2 ||
                          BLOCK_SIZE == 4 || BLOCK_SIZE == 8)) begin : g_bad_cfg
    $error("coherency_unit_mesi_n: illegal CPUID/NCPUS/BLOCK_SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_UPGR, S_WB, S_SCHK, S_SSEND, S_SMISS
  } state_e;

  state_e                state_q, state_d, replay_st;
  logic [1:0]            pend_kind_q, kind_eff, acc_kind;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [DW-1:0]         pend_wdata_q;
  logic                  pend_vld_q;
  logic                  acc, in_snoop, inv_hit;
  logic                  ev_e, ev_s, ev_m, ev_i, ev_hit;
  logic [STAT_WIDTH-1:0] to_m_q, to_e_q, to_s_q, to_i_q, hits_q;

  function automatic logic line_eq(input logic [ADDR_WIDTH-1:0] a,
                                   input logic [ADDR_WIDTH-1:0] b);
    return a[ADDR_WIDTH-1:LSB] == b[ADDR_WIDTH-1:LSB];
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // Request acceptance, and upgrade->write conversion when a snoop kills our line
  always_comb begin
    acc      = (state_q == S_IDLE) && !bus_ccwait &&
               (req_wb || req_upgrade || req_wen || req_ren);
    acc_kind = req_wb ? K_WB : req_upgrade ? K_UP : req_wen ? K_WR : K_RD;
    in_snoop = (state_q == S_SCHK) || (state_q == S_SSEND) || (state_q == S_SMISS);
    inv_hit  = in_snoop && bus_ccinv && pend_vld_q && line_eq(bus_snoopaddr, pend_addr_q);
    kind_eff = (pend_kind_q == K_UP && inv_hit) ? K_WR : pend_kind_q;
    replay_st = S_IDLE;
    if (pend_vld_q) begin
      case (kind_eff)
        K_RD:    replay_st = S_READ;
        K_WR:    replay_st = S_WRITE;
        K_UP:    replay_st = S_UPGR;
        default: replay_st = S_WB;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; snoops always win over requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus_ccwait)       state_d = S_SCHK;
        else if (req_wb)      state_d = S_WB;
        else if (req_upgrade) state_d = S_UPGR;
        else if (req_wen)     state_d = S_WRITE;
        else if (req_ren)     state_d = S_READ;
      end
      S_READ, S_WRITE, S_UPGR, S_WB: begin
        if (bus_ccwait)      state_d = S_SCHK;
        else if (!bus_dwait) state_d = S_IDLE;
      end
      S_SCHK:  if (!snp_busy) state_d = snp_hit ? S_SSEND : S_SMISS;
      S_SSEND, S_SMISS: if (!bus_ccwait) state_d = replay_st;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and statistic events; everything is quiet while reset is held
  always_comb begin
    req_busy = 1'b1;  req_done = 1'b0;  req_rdata = '0;  req_state = ST_I;
    snp_req = 1'b0;   snp_addr = '0;    snp_state = 2'd0; snp_commit = 1'b0;
    bus_ren = 1'b0;   bus_wen = 1'b0;   bus_rfo = 1'b0;  bus_upgr = 1'b0;
    bus_addr = '0;    bus_store = '0;
    bus_snoopdone = 1'b0; bus_snoophit = 1'b0; bus_dirty = 1'b0;
    ev_e = 1'b0; ev_s = 1'b0; ev_m = 1'b0; ev_i = 1'b0; ev_hit = 1'b0;
    if (!RST) begin
      case (state_q)
        S_READ, S_WRITE, S_UPGR, S_WB: begin
          if (!bus_ccwait) begin
            bus_addr = pend_addr_q;
            case (state_q)
              S_READ:  bus_ren = 1'b1;
              S_WRITE: begin bus_ren = 1'b1; bus_rfo = 1'b1; end
              S_UPGR: begin
                if (UPGRADE_MODE != 0) bus_upgr = 1'b1;
                else begin bus_ren = 1'b1; bus_rfo = 1'b1; end
              end
              default: begin bus_wen = 1'b1; bus_store = pend_wdata_q; end
            endcase
            if (!bus_dwait) begin
              req_busy  = 1'b0;
              req_done  = 1'b1;
              req_rdata = bus_dload;
              case (state_q)
                S_READ: begin
                  req_state = bus_exclusive ? ST_E : ST_S;
                  ev_e = bus_exclusive;
                  ev_s = !bus_exclusive;
                end
                S_WRITE, S_UPGR: begin req_state = ST_M; ev_m = 1'b1; end
                default:         req_state = ST_I;
              endcase
            end
          end
        end
        S_SCHK: begin
          snp_req  = 1'b1;
          snp_addr = bus_snoopaddr;
          if (!snp_busy && !snp_hit) bus_snoopdone = 1'b1;
          if (!snp_busy && snp_hit)  ev_hit = 1'b1;
        end
        S_SSEND: begin
          snp_req       = 1'b1;
          bus_snoophit  = 1'b1;
          bus_snoopdone = 1'b1;
          bus_store     = snp_data;
          bus_dirty     = snp_dirty;
          snp_state     = bus_ccinv ? ST_I : ST_S;
          if (!bus_ccwait) begin
            snp_commit = 1'b1;
            ev_i = bus_ccinv;
            ev_s = !bus_ccinv;
          end
        end
        S_SMISS: bus_snoopdone = 1'b1;
        default: ;
      endcase
    end
  end

  // Pending-request register: latched on accept, dropped on completion
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_vld_q   <= 1'b0;
      pend_kind_q  <= K_RD;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else if (acc) begin
      pend_vld_q   <= 1'b1;
      pend_kind_q  <= acc_kind;
      pend_addr_q  <= req_addr;
      pend_wdata_q <= req_wdata;
    end else if (req_done) begin
      pend_vld_q   <= 1'b0;
    end else if (in_snoop) begin
      pend_kind_q  <= kind_eff;
    end
  end

  // Saturating transition counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_m_q <= '0; to_e_q <= '0; to_s_q <= '0; to_i_q <= '0; hits_q <= '0;
    end else begin
      if (ev_m)   to_m_q <= sat_inc(to_m_q);
      if (ev_e)   to_e_q <= sat_inc(to_e_q);
      if (ev_s)   to_s_q <= sat_inc(to_s_q);
      if (ev_i)   to_i_q <= sat_inc(to_i_q);
      if (ev_hit) hits_q <= sat_inc(hits_q);
    end
  end

  assign stat_to_m       = RST ? '0 : to_m_q;
  assign stat_to_e       = RST ? '0 : to_e_q;
  assign stat_to_s       = RST ? '0 : to_s_q;
  assign stat_to_i       = RST ? '0 : to_i_q;
  assign stat_snoop_hits = RST ? '0 : hits_q;

endmodule

// File: tb/tb_coherency_unit_mesi_n.sv
// Directed bench for coherency_unit_mesi_n. A second instance with 2-bit
// statistics shares every input to show counter saturation.
module tb_coherency_unit_mesi_n;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_ren, req_wen, req_wb, req_upgrade;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_busy, req_done;
  logic [63:0] req_rdata;
  logic [1:0]  req_state;
  logic        snp_req, snp_commit;
  logic [31:0] snp_addr;
  logic [1:0]  snp_state;
  logic        snp_busy, snp_hit, snp_dirty;
  logic [63:0] snp_data;
  logic        bus_ren, bus_wen, bus_rfo, bus_upgr;
  logic [31:0] bus_addr;
  logic [63:0] bus_store;
  logic        bus_dwait, bus_exclusive, bus_ccwait, bus_ccinv;
  logic [63:0] bus_dload;
  logic [31:0] bus_snoopaddr;
  logic        bus_snoopdone, bus_snoophit, bus_dirty;
  logic [31:0] stat_to_m, stat_to_e, stat_to_s, stat_to_i, stat_snoop_hits;

  // saturation instance outputs
  logic        s_busy, s_done, s_sreq, s_commit, s_ren, s_wen, s_rfo, s_upgr;
  logic        s_sdone, s_shit, s_dirty;
  logic [63:0] s_rdata, s_store;
  logic [1:0]  s_rstate, s_sstate;
  logic [31:0] s_saddr, s_baddr;
  logic [1:0]  s_to_m, s_to_e, s_to_s, s_to_i, s_hits;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  coherency_unit_mesi_n u_dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_wb(req_wb), .req_upgrade(req_upgrade),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_busy(req_busy), .req_rdata(req_rdata), .req_state(req_state), .req_done(req_done),
    .snp_req(snp_req), .snp_addr(snp_addr), .snp_state(snp_state), .snp_commit(snp_commit),
    .snp_busy(snp_busy), .snp_hit(snp_hit), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_rfo(bus_rfo), .bus_upgr(bus_upgr),
    .bus_addr(bus_addr), .bus_store(bus_store),
    .bus_dwait(bus_dwait), .bus_exclusive(bus_exclusive), .bus_ccwait(bus_ccwait),
    .bus_ccinv(bus_ccinv), .bus_dload(bus_dload), .bus_snoopaddr(bus_snoopaddr),
    .bus_snoopdone(bus_snoopdone), .bus_snoophit(bus_snoophit), .bus_dirty(bus_dirty),
    .stat_to_m(stat_to_m), .stat_to_e(stat_to_e), .stat_to_s(stat_to_s),
    .stat_to_i(stat_to_i), .stat_snoop_hits(stat_snoop_hits)
  );

  coherency_unit_mesi_n #(.STAT_WIDTH(2)) u_sat (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_wb(req_wb), .req_upgrade(req_upgrade),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_busy(s_busy), .req_rdata(s_rdata), .req_state(s_rstate), .req_done(s_done),
    .snp_req(s_sreq), .snp_addr(s_saddr), .snp_state(s_sstate), .snp_commit(s_commit),
    .snp_busy(snp_busy), .snp_hit(snp_hit), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .bus_ren(s_ren), .bus_wen(s_wen), .bus_rfo(s_rfo), .bus_upgr(s_upgr),
    .bus_addr(s_baddr), .bus_store(s_store),
    .bus_dwait(bus_dwait), .bus_exclusive(bus_exclusive), .bus_ccwait(bus_ccwait),
    .bus_ccinv(bus_ccinv), .bus_dload(bus_dload), .bus_snoopaddr(bus_snoopaddr),
    .bus_snoopdone(s_sdone), .bus_snoophit(s_shit), .bus_dirty(s_dirty),
    .stat_to_m(s_to_m), .stat_to_e(s_to_e), .stat_to_s(s_to_s),
    .stat_to_i(s_to_i), .stat_snoop_hits(s_hits)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are changed just after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    req_ren = 0; req_wen = 0; req_wb = 0; req_upgrade = 0;
    req_addr = '0; req_wdata = '0;
    snp_busy = 0; snp_hit = 0; snp_dirty = 0; snp_data = '0;
    bus_dwait = 0; bus_exclusive = 0; bus_ccwait = 0; bus_ccinv = 0;
    bus_dload = '0; bus_snoopaddr = '0;
  endtask

  initial begin
    clear_in();
    RST = 1;
    // ---- reset ----
    tick(); tick(); #1;
    chk("rst_busy", req_busy, 1);
    chk("rst_state", req_state, 3);
    chk("rst_done", req_done, 0);
    chk("rst_bus_ren", bus_ren, 0);
    chk("rst_stat_e", stat_to_e, 0);
    RST = 0;
    tick(); #1;
    chk("idle_busy", req_busy, 1);
    chk("idle_state", req_state, 3);
    chk("idle_snp_req", snp_req, 0);

    // ---- read miss, 3 wait cycles, exclusive ----
    req_ren = 1; req_addr = 32'h100; bus_dwait = 1; #1;          // cycle 1
    chk("rd_c1_bus_ren", bus_ren, 0);
    tick(); req_ren = 0; req_addr = '0; #1;                       // cycle 2
    chk("rd_c2_bus_ren", bus_ren, 1);
    chk("rd_c2_addr", bus_addr, 32'h100);
    chk("rd_c2_done", req_done, 0);
    tick(); tick(); #1;                                           // cycle 4
    chk("rd_c4_done", req_done, 0);
    tick(); bus_dwait = 0; bus_exclusive = 1;                     // cycle 5
    bus_dload = 64'hA5A5_5A5A_1234_5678; #1;
    chk("rd_c5_done", req_done, 1);
    chk("rd_c5_busy", req_busy, 0);
    chk("rd_c5_state", req_state, 1);
    chk("rd_c5_rdata", req_rdata, 64'hA5A5_5A5A_1234_5678);
    tick(); bus_exclusive = 0; bus_dload = '0; #1;
    chk("rd_c6_done", req_done, 0);
    chk("rd_c6_busy", req_busy, 1);
    chk("rd_stat_e", stat_to_e, 1);

    // ---- snoop hit with invalidate ----
    bus_ccwait = 1; bus_snoopaddr = 32'h200; snp_busy = 1; snp_hit = 1;
    snp_dirty = 1; bus_ccinv = 1; snp_data = 64'hDEAD_BEEF_CAFE_F00D; #1;
    chk("sn_idle_req", snp_req, 0);
    tick(); #1;
    chk("sn_chk_req", snp_req, 1);
    chk("sn_chk_addr", snp_addr, 32'h200);
    chk("sn_chk_done", bus_snoopdone, 0);
    tick(); snp_busy = 0; #1;
    chk("sn_resolve_done", bus_snoopdone, 0);
    tick(); #1;
    chk("sn_send_hit", bus_snoophit, 1);
    chk("sn_send_dirty", bus_dirty, 1);
    chk("sn_send_done", bus_snoopdone, 1);
    chk("sn_send_state", snp_state, 3);
    chk("sn_send_store", bus_store, 64'hDEAD_BEEF_CAFE_F00D);
    chk("sn_send_commit_hold", snp_commit, 0);
    chk("sn_hits", stat_snoop_hits, 1);
    bus_ccwait = 0; #1;
    chk("sn_commit", snp_commit, 1);
    tick(); clear_in(); #1;
    chk("sn_commit_after", snp_commit, 0);
    chk("sn_stat_i", stat_to_i, 1);

    // ---- preempted upgrade, snoop invalidates same line ----
    req_upgrade = 1; req_addr = 32'h300; bus_dwait = 1; #1;
    tick(); req_upgrade = 0; req_addr = '0; #1;
    chk("up_upgr", bus_upgr, 1);
    chk("up_rfo", bus_rfo, 0);
    chk("up_addr", bus_addr, 32'h300);
    bus_ccwait = 1; bus_snoopaddr = 32'h304; bus_ccinv = 1; snp_hit = 1; #1;
    chk("up_preempt_upgr", bus_upgr, 0);
    chk("up_preempt_addr", bus_addr, 0);
    tick(); #1;                                                   // SNP_CHK resolves
    chk("up_chk_req", snp_req, 1);
    tick(); bus_ccwait = 0; #1;                                   // SNP_SEND exits
    chk("up_send_commit", snp_commit, 1);
    tick(); clear_in(); bus_dload = 64'h1111_2222_3333_4444; #1;  // replay
    chk("up_replay_rfo", bus_rfo, 1);
    chk("up_replay_ren", bus_ren, 1);
    chk("up_replay_upgr", bus_upgr, 0);
    chk("up_replay_addr", bus_addr, 32'h300);
    chk("up_replay_done", req_done, 1);
    chk("up_replay_state", req_state, 0);
    tick(); bus_dload = '0; #1;
    chk("up_stat_m", stat_to_m, 1);
    chk("up_stat_i", stat_to_i, 2);

    // ---- writeback and snoop in the same idle cycle ----
    req_wb = 1; req_addr = 32'h400; req_wdata = 64'h0BAD_F00D_1357_9BDF;
    bus_ccwait = 1; bus_snoopaddr = 32'h500; #1;
    chk("wb_idle_done", req_done, 0);
    chk("wb_idle_wen", bus_wen, 0);
    tick(); #1;                                                   // SNP_CHK miss
    chk("wb_chk_sdone", bus_snoopdone, 1);
    chk("wb_chk_wen", bus_wen, 0);
    tick(); #1;                                                   // SNP_MISS
    chk("wb_miss_sdone", bus_snoopdone, 1);
    chk("wb_miss_shit", bus_snoophit, 0);
    bus_ccwait = 0;
    tick(); #1;                                                   // IDLE, accept wb
    chk("wb_acc_wen", bus_wen, 0);
    tick(); req_wb = 0; req_wdata = 64'hFFFF_0000_FFFF_0000; #1;  // WRITEBACK
    chk("wb_wen", bus_wen, 1);
    chk("wb_store", bus_store, 64'h0BAD_F00D_1357_9BDF);
    chk("wb_addr", bus_addr, 32'h400);
    chk("wb_done", req_done, 1);
    chk("wb_state", req_state, 3);
    tick(); clear_in(); #1;
    chk("wb_stat_i", stat_to_i, 2);

    // ---- four shared reads: 2-bit counter saturates ----
    for (int i = 0; i < 4; i++) begin
      req_ren = 1; req_addr = 32'h800 + 32'(i * 8); #1;
      tick(); req_ren = 0; #1;
      chk("sat_rd_done", req_done, 1);
      chk("sat_rd_state", req_state, 2);
      tick();
    end
    #1;
    chk("sat_stat_s_w2", {62'd0, s_to_s}, 3);
    chk("sat_stat_s_w32", stat_to_s, 4);
    chk("sat_stat_e_w2", {62'd0, s_to_e}, 1);

    // ---- reset while in SNP_SEND ----
    bus_ccwait = 1; snp_hit = 1; bus_snoopaddr = 32'h900; #1;
    tick(); tick(); #1;                                           // SNP_SEND
    chk("rs_send_state", snp_state, 2);
    chk("rs_hits", stat_snoop_hits, 3);
    RST = 1; bus_ccwait = 0; #1;
    chk("rs_commit", snp_commit, 0);
    chk("rs_shit", bus_snoophit, 0);
    chk("rs_stat_s_gated", stat_to_s, 0);
    tick(); RST = 0; clear_in(); #1;
    chk("rs_after_sreq", snp_req, 0);
    chk("rs_after_commit", snp_commit, 0);
    chk("rs_after_busy", req_busy, 1);
    chk("rs_after_stat_s", stat_to_s, 0);
    chk("rs_after_stat_m", stat_to_m, 0);
    chk("rs_after_hits", stat_snoop_hits, 0);
    tick(); #1;
    chk("rs_idle_bus_ren", bus_ren, 0);
    chk("rs_idle_state", req_state, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
